// File: rtl/his_acq_sequencer.sv
// Frame sequencer for a TDC histogram builder: it clears the histogram, then collects
// PIXEL_NUM timestamps per acquisition over ACQ_NUM acquisitions, and counts completed frames.
module his_acq_sequencer #(
    parameter int NP           = 10,
    parameter int PIXEL_NUM    = 6,
    parameter int ACQ_NUM      = 2,
    parameter int CLR_CYCLES   = 2,
    parameter int GAP_CYCLES   = 4,
    parameter int DRAIN_CYCLES = 4,
    localparam int PW   = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1,
    localparam int AW   = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1,
    localparam int CMAX = (CLR_CYCLES > GAP_CYCLES)
                          ? ((CLR_CYCLES > DRAIN_CYCLES) ? CLR_CYCLES : DRAIN_CYCLES)
                          : ((GAP_CYCLES > DRAIN_CYCLES) ? GAP_CYCLES : DRAIN_CYCLES),
    localparam int CW   = $clog2(CMAX + 1)
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    input  logic          abort,
    input  logic          tdcValid,
    input  logic [NP-1:0] tdcData,
    output logic          tdcReady,
    output logic          wrEn,
    output logic [NP-1:0] data,
    output logic [PW-1:0] pixIdx,
    output logic [AW-1:0] acqIdx,
    output logic          hbRes,
    output logic          busy,
    output logic          frameDone,
    output logic [15:0]   frameCnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACQ   = 3'd2,
        S_GAP   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pix_cnt_q, pix_cnt_d;
    logic [AW-1:0] acq_cnt_q, acq_cnt_d;
    logic          xfer_s;

    logic          tdc_ready_q, tdc_ready_d;
    logic          wr_en_q, wr_en_d;
    logic [NP-1:0] data_q, data_d;
    logic [PW-1:0] pix_idx_q, pix_idx_d;
    logic [AW-1:0] acq_idx_q, acq_idx_d;
    logic          hb_res_q, hb_res_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    // Next-state, phase timer and pixel/acquisition counters; abort overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pix_cnt_d = pix_cnt_q;
        acq_cnt_d = acq_cnt_q;
        xfer_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d     = {CW{1'b0}};
                pix_cnt_d = {PW{1'b0}};
                acq_cnt_d = {AW{1'b0}};
                if (start) state_d = S_CLEAR;
                else       state_d = S_IDLE;
            end
            S_CLEAR: begin
                if (cnt_q == CW'(CLR_CYCLES - 1)) begin
                    state_d = S_ACQ;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ACQ: begin
                if (tdcValid && tdc_ready_q) begin
                    xfer_s = 1'b1;
                    if (pix_cnt_q == PW'(PIXEL_NUM - 1)) begin
                        pix_cnt_d = {PW{1'b0}};
                        if (acq_cnt_q == AW'(ACQ_NUM - 1)) begin
                            state_d = S_DRAIN;
                        end else begin
                            acq_cnt_d = acq_cnt_q + AW'(1);
                            state_d   = S_GAP;
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + PW'(1);
                    end
                end else begin
                    xfer_s = 1'b0;
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    state_d = S_ACQ;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            xfer_s  = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // Output values for the next cycle; all derived from the next state so they come straight off flops.
    always_comb begin
        tdc_ready_d  = (state_d == S_ACQ);
        hb_res_d     = (state_d != S_CLEAR);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_DONE);
        frame_cnt_d  = frame_done_d ? (frame_cnt_q + 16'd1) : frame_cnt_q;
        wr_en_d      = xfer_s;
        data_d       = xfer_s ? tdcData   : data_q;
        pix_idx_d    = xfer_s ? pix_cnt_q : pix_idx_q;
        acq_idx_d    = xfer_s ? acq_cnt_q : acq_idx_q;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CW{1'b0}};
            pix_cnt_q    <= {PW{1'b0}};
            acq_cnt_q    <= {AW{1'b0}};
            tdc_ready_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            data_q       <= {NP{1'b0}};
            pix_idx_q    <= {PW{1'b0}};
            acq_idx_q    <= {AW{1'b0}};
            hb_res_q     <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            acq_cnt_q    <= acq_cnt_d;
            tdc_ready_q  <= tdc_ready_d;
            wr_en_q      <= wr_en_d;
            data_q       <= data_d;
            pix_idx_q    <= pix_idx_d;
            acq_idx_q    <= acq_idx_d;
            hb_res_q     <= hb_res_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign tdcReady  = tdc_ready_q;
    assign wrEn      = wr_en_q;
    assign data      = data_q;
    assign pixIdx    = pix_idx_q;
    assign acqIdx    = acq_idx_q;
    assign hbRes     = hb_res_q;
    assign busy      = busy_q;
    assign frameDone = frame_done_q;
    assign frameCnt  = frame_cnt_q;

endmodule

// File: tb/tb_his_acq_sequencer.sv
// Bench for his_acq_sequencer: frame timing derived from the parameter arithmetic, plus a
// write scoreboard fed by a holding valid/ready source with directed and $urandom valid patterns.
module tb_his_acq_sequencer;

    localparam int NP    = 10;
    localparam int PIX   = 6;
    localparam int ACQN  = 2;
    localparam int CLR   = 2;
    localparam int GAP   = 4;
    localparam int DRAIN = 4;
    localparam int PW    = 3;
    localparam int AW    = 1;

    logic          clk = 1'b0;
    logic          res = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          tdcValid = 1'b0;
    logic [NP-1:0] tdcData = '0;
    logic          tdcReady, wrEn, hbRes, busy, frameDone;
    logic [NP-1:0] data;
    logic [PW-1:0] pixIdx;
    logic [AW-1:0] acqIdx;
    logic [15:0]   frameCnt;

    his_acq_sequencer #(.NP(NP), .PIXEL_NUM(PIX), .ACQ_NUM(ACQN), .CLR_CYCLES(CLR),
                        .GAP_CYCLES(GAP), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .res(res), .start(start), .abort(abort),
        .tdcValid(tdcValid), .tdcData(tdcData), .tdcReady(tdcReady),
        .wrEn(wrEn), .data(data), .pixIdx(pixIdx), .acqIdx(acqIdx),
        .hbRes(hbRes), .busy(busy), .frameDone(frameDone), .frameCnt(frameCnt));

    always #5 clk = ~clk;

    typedef struct { logic [NP-1:0] d; int pix; int acq; } wr_t;
    wr_t           exp_q[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            wr_k = 0;
    logic [NP-1:0] next_data = 10'd108;
    bit            pending = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // First ACQ cycle of acquisition a, counting the start cycle as cycle 0, valid held high.
    function automatic int acq_first(input int a);
        return 1 + CLR + a * (PIX + GAP);
    endfunction

    function automatic bit rdy_at(input int c);
        for (int a = 0; a < ACQN; a++)
            if (c >= acq_first(a) && c < acq_first(a) + PIX) return 1'b1;
        return 1'b0;
    endfunction

    // Called at a falling edge: score this cycle's write, drive inputs, advance one cycle.
    task automatic drive(input bit st, input bit ab, input bit rs, input bit want);
        wr_t e;
        if (wrEn) begin
            chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_data", 32'(data), 32'(e.d));
                chk("wr_pix", 32'(pixIdx), 32'(e.pix));
                chk("wr_acq", 32'(acqIdx), 32'(e.acq));
            end
        end
        start = st;
        abort = ab;
        res   = !rs;
        if (!pending) begin
            tdcValid = want;
            tdcData  = next_data;
        end
        if (tdcValid && tdcReady) begin
            if (!ab && !rs) begin
                e.d = tdcData; e.pix = wr_k % PIX; e.acq = wr_k / PIX;
                exp_q.push_back(e);
                wr_k++;
            end
            next_data = next_data + 10'd1;
            pending   = 1'b0;
        end else begin
            pending = tdcValid;
        end
        @(negedge clk);
        if (ab || rs) exp_q.delete();
    endtask

    // Valid held high; optional stray starts (s1/s2), abort cycle or reset cycle (-1 = none).
    task automatic run_directed(input logic [15:0] base, input int s1, input int s2,
                                input int ab_c, input int rs_c);
        int done_c = acq_first(ACQN - 1) + PIX + DRAIN;
        int kill   = (ab_c >= 0) ? ab_c : rs_c;
        bit killed;
        logic [15:0] fc;
        wr_k = 0;
        for (int c = 0; c <= done_c + 3; c++) begin
            if (c >= 1) begin
                killed = (kill >= 0) && (c > kill);
                chk("hbRes", 32'(hbRes), killed ? 32'd1 : 32'(!(c <= CLR)));
                chk("tdcReady", 32'(tdcReady), killed ? 32'd0 : 32'(rdy_at(c)));
                chk("wrEn", 32'(wrEn), killed ? 32'd0 : 32'(rdy_at(c - 1)));
                chk("busy", 32'(busy), killed ? 32'd0 : 32'(c <= done_c));
                chk("frameDone", 32'(frameDone), killed ? 32'd0 : 32'(c == done_c));
                if (killed && rs_c >= 0) fc = 16'd0;
                else if (killed)         fc = base;
                else                     fc = base + 16'(c >= done_c);
                chk("frameCnt", 32'(frameCnt), 32'(fc));
                if (rs_c >= 0 && c == rs_c + 1) begin
                    chk("rst_data", 32'(data), 32'd0);
                    chk("rst_pix", 32'(pixIdx), 32'd0);
                    chk("rst_acq", 32'(acqIdx), 32'd0);
                end
            end
            drive(c == 0 || c == s1 || c == s2, c == ab_c, c == rs_c, 1'b1);
        end
    endtask

    // Toggled or random valid; checks write count, single frameDone, gap length, counter step.
    task automatic run_random(input bit toggle, input logic [15:0] base);
        int  wr_n = 0, dn = 0, low_run = 0, tail = 0, c = 0;
        bit  prev_r = 1'b0, seen = 1'b0, wv;
        wr_k = 0;
        while (c < 400 && tail < 3) begin
            if (wrEn) wr_n++;
            if (frameDone) dn++;
            if (tdcReady && !prev_r && seen) chk("gap_len", 32'(low_run), 32'(GAP));
            if (tdcReady) begin seen = 1'b1; low_run = 0; end
            else if (seen) low_run++;
            prev_r = tdcReady;
            wv = toggle ? (c % 2 == 0) : 1'($urandom % 2);
            drive(c == 0, 1'b0, 1'b0, wv);
            if (dn > 0) tail++;
            c++;
        end
        chk("rand_wr_count", 32'(wr_n), 32'(PIX * ACQN));
        chk("rand_done_count", 32'(dn), 32'd1);
        chk("rand_frameCnt", 32'(frameCnt), 32'(base + 16'd1));
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        res = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tdcReady", 32'(tdcReady), 32'd0);
        chk("rst_wrEn", 32'(wrEn), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_pixIdx", 32'(pixIdx), 32'd0);
        chk("rst_acqIdx", 32'(acqIdx), 32'd0);
        chk("rst_hbRes", 32'(hbRes), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frameDone", 32'(frameDone), 32'd0);
        chk("rst_frameCnt", 32'(frameCnt), 32'd0);
        res = 1'b1;
        @(negedge clk);

        run_directed(16'd0, -1, -1, -1, -1);
        run_directed(16'd1, 5, 20, -1, -1);
        run_directed(16'd2, -1, -1, acq_first(1) + 2, -1);
        run_directed(16'd2, -1, -1, -1, -1);

        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("abort_start_busy", 32'(busy), 32'd0);
        chk("abort_start_hbRes", 32'(hbRes), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_start_busy2", 32'(busy), 32'd0);
        chk("abort_start_ready", 32'(tdcReady), 32'd0);

        run_random(1'b1, 16'd3);
        run_random(1'b0, 16'd4);
        run_random(1'b0, 16'd5);

        run_directed(16'd6, -1, -1, -1, acq_first(0) + PIX + 1);

        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        chk("preload_frameCnt", 32'(frameCnt), 32'h0000_FFFF);
        run_directed(16'hFFFF, -1, -1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
